// File: rtl/sd_init_sequencer_if.sv
// Byte-exchange handshake between the SD init sequencer (master) and the
// SPI byte stage (slave) that drives SD_CLK/SD_MOSI/SD_CS.
interface sd_init_sequencer_if;
  logic       xfer_req;
  logic [7:0] xfer_tx;
  logic       cs_assert;
  logic       xfer_done;
  logic [7:0] xfer_rx;

  modport master (output xfer_req, xfer_tx, cs_assert, input xfer_done, xfer_rx);
  modport slave  (input xfer_req, xfer_tx, cs_assert, output xfer_done, xfer_rx);
endinterface

// File: rtl/sd_init_sequencer.sv
// SPI-mode SD card initialisation sequencer: dummy clocks, CMD0/CMD8/CMD55+ACMD41/CMD58.
// Define SD_INIT_CRC7_EN to generate command CRC bytes with a serial CRC7; otherwise fixed CRC bytes.
module sd_init_sequencer #(
  parameter int NCR_MAX        = 8,
  parameter int ACMD41_RETRIES = 1000,
  parameter int DUMMY_BYTES    = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  sd_init_sequencer_if.master        spi,
  output logic                       busy,
  output logic                       init_done,
  output logic                       init_err,
  output logic [2:0]                 err_code,
  output logic                       card_v2,
  output logic                       card_hc
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DUMMY     = 3'd1;
  localparam logic [2:0] ST_CMD_SEND  = 3'd2;
  localparam logic [2:0] ST_RESP_WAIT = 3'd3;
  localparam logic [2:0] ST_RESP_TAIL = 3'd4;
  localparam logic [2:0] ST_GAP       = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;
  localparam logic [2:0] ST_ERR       = 3'd7;

  localparam logic [2:0] C_CMD0   = 3'd0;
  localparam logic [2:0] C_CMD8   = 3'd1;
  localparam logic [2:0] C_CMD55  = 3'd2;
  localparam logic [2:0] C_ACMD41 = 3'd3;
  localparam logic [2:0] C_CMD58  = 3'd4;

  localparam logic [7:0]  DUMMY_LAST = 8'(DUMMY_BYTES - 1);
  localparam logic [7:0]  NCR_LAST   = 8'(NCR_MAX - 1);
  localparam logic [15:0] RETRY_LAST = 16'(ACMD41_RETRIES - 1);

  logic [2:0]  state_r, state_n;
  logic [2:0]  cmd_r, cmd_n;
  logic [7:0]  cnt_r, cnt_n;
  logic [15:0] retry_r, retry_n;
  logic [31:0] tail_r, tail_s;
  logic        xfer_req_r, cs_assert_r, busy_r, init_done_r, init_err_r;
  logic        card_v2_r, card_hc_r, v2_n, hc_n;
  logic [7:0]  xfer_tx_r;
  logic [2:0]  err_code_r, code_n;
  logic        accept_s, cs_s;
  logic [5:0]  cmd_idx_s;
  logic [31:0] cmd_arg_s;
  logic [7:0]  crc_byte_s, tx_s;

  assign accept_s     = xfer_req_r & spi.xfer_done;
  assign tail_s       = {tail_r[23:0], spi.xfer_rx};
  assign spi.xfer_req  = xfer_req_r;
  assign spi.xfer_tx   = xfer_tx_r;
  assign spi.cs_assert = cs_assert_r;
  assign busy         = busy_r;
  assign init_done    = init_done_r;
  assign init_err     = init_err_r;
  assign err_code     = err_code_r;
  assign card_v2      = card_v2_r;
  assign card_hc      = card_hc_r;

  // Command index and argument for the command currently being issued
  always_comb begin
    cmd_idx_s = 6'd0;
    cmd_arg_s = 32'h0000_0000;
    case (cmd_r)
      C_CMD0:   cmd_idx_s = 6'd0;
      C_CMD8:   begin cmd_idx_s = 6'd8; cmd_arg_s = 32'h0000_01AA; end
      C_CMD55:  cmd_idx_s = 6'd55;
      C_ACMD41: begin
        cmd_idx_s = 6'd41;
        cmd_arg_s = card_v2_r ? 32'h4000_0000 : 32'h0000_0000;
      end
      C_CMD58:  cmd_idx_s = 6'd58;
      default:  cmd_idx_s = 6'd0;
    endcase
  end

`ifdef SD_INIT_CRC7_EN
  logic [6:0] crc_r;

  function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  assign crc_byte_s = {crc_r, 1'b1};

  // CRC7 accumulates over command bytes 0..4 as each is accepted; cleared otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_r <= 7'd0;
    end else if (accept_s) begin
      if ((state_r == ST_CMD_SEND) && (cnt_r != 8'd5)) begin
        crc_r <= crc7_byte(crc_r, xfer_tx_r);
      end else begin
        crc_r <= 7'd0;
      end
    end else begin
      crc_r <= crc_r;
    end
  end
`else
  // Fixed CRC bytes; only CMD0 and CMD8 are checked by cards in SPI mode
  always_comb begin
    crc_byte_s = 8'hFF;
    case (cmd_r)
      C_CMD0:  crc_byte_s = 8'h95;
      C_CMD8:  crc_byte_s = 8'h87;
      default: crc_byte_s = 8'hFF;
    endcase
  end
`endif

  // Byte and chip-select for the next exchange, derived from the current state
  always_comb begin
    tx_s = 8'hFF;
    cs_s = 1'b0;
    case (state_r)
      ST_CMD_SEND: begin
        cs_s = 1'b1;
        case (cnt_r)
          8'd0:    tx_s = {2'b01, cmd_idx_s};
          8'd1:    tx_s = cmd_arg_s[31:24];
          8'd2:    tx_s = cmd_arg_s[23:16];
          8'd3:    tx_s = cmd_arg_s[15:8];
          8'd4:    tx_s = cmd_arg_s[7:0];
          8'd5:    tx_s = crc_byte_s;
          default: tx_s = 8'hFF;
        endcase
      end
      ST_RESP_WAIT, ST_RESP_TAIL: cs_s = 1'b1;
      default: cs_s = 1'b0;
    endcase
  end

  // Sequencing decision taken when the current byte completes
  always_comb begin
    state_n = state_r;
    cmd_n   = cmd_r;
    cnt_n   = cnt_r + 8'd1;
    retry_n = retry_r;
    code_n  = 3'd0;
    v2_n    = card_v2_r;
    hc_n    = card_hc_r;
    case (state_r)
      ST_DUMMY: begin
        if (cnt_r == DUMMY_LAST) begin
          state_n = ST_CMD_SEND;
          cmd_n   = C_CMD0;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt_r + 8'd1;
        end
      end
      ST_CMD_SEND: begin
        if (cnt_r == 8'd5) begin
          state_n = ST_RESP_WAIT;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt_r + 8'd1;
        end
      end
      ST_RESP_WAIT: begin
        if (!spi.xfer_rx[7]) begin
          cnt_n = 8'd0;
          case (cmd_r)
            C_CMD0: begin
              if (spi.xfer_rx == 8'h01) begin
                state_n = ST_GAP; cmd_n = C_CMD8;
              end else begin
                state_n = ST_ERR; code_n = 3'd1;
              end
            end
            C_CMD8: begin
              if (spi.xfer_rx == 8'h01) begin
                state_n = ST_RESP_TAIL;
              end else if (spi.xfer_rx[2]) begin
                v2_n = 1'b0; state_n = ST_GAP; cmd_n = C_CMD55;
              end else begin
                state_n = ST_ERR; code_n = 3'd2;
              end
            end
            C_CMD55: begin
              state_n = ST_GAP; cmd_n = C_ACMD41;
            end
            C_ACMD41: begin
              if (spi.xfer_rx == 8'h00) begin
                if (card_v2_r) begin
                  state_n = ST_GAP; cmd_n = C_CMD58;
                end else begin
                  state_n = ST_DONE;
                end
              end else if ((spi.xfer_rx == 8'h01) && (retry_r != RETRY_LAST)) begin
                retry_n = retry_r + 16'd1; state_n = ST_GAP; cmd_n = C_CMD55;
              end else begin
                state_n = ST_ERR; code_n = 3'd3;
              end
            end
            C_CMD58: begin
              if (spi.xfer_rx == 8'h00) begin
                state_n = ST_RESP_TAIL;
              end else begin
                state_n = ST_ERR; code_n = 3'd4;
              end
            end
            default: begin
              state_n = ST_ERR; code_n = 3'd7;
            end
          endcase
        end else if (cnt_r == NCR_LAST) begin
          state_n = ST_ERR; code_n = 3'd5;
        end else begin
          cnt_n = cnt_r + 8'd1;
        end
      end
      ST_RESP_TAIL: begin
        if (cnt_r != 8'd3) begin
          cnt_n = cnt_r + 8'd1;
        end else if (cmd_r == C_CMD58) begin
          hc_n = tail_s[30]; state_n = ST_DONE; cnt_n = 8'd0;
        end else if (tail_s[11:0] == 12'h1AA) begin
          v2_n = 1'b1; state_n = ST_GAP; cmd_n = C_CMD55; cnt_n = 8'd0;
        end else begin
          state_n = ST_ERR; code_n = 3'd2; cnt_n = 8'd0;
        end
      end
      ST_GAP: begin
        state_n = ST_CMD_SEND;
        cnt_n   = 8'd0;
      end
      default: begin
        state_n = state_r;
        cnt_n   = cnt_r;
      end
    endcase
  end

  // Main state, handshake and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      cmd_r       <= C_CMD0;
      cnt_r       <= 8'd0;
      retry_r     <= 16'd0;
      tail_r      <= 32'd0;
      xfer_req_r  <= 1'b0;
      xfer_tx_r   <= 8'hFF;
      cs_assert_r <= 1'b0;
      busy_r      <= 1'b0;
      init_done_r <= 1'b0;
      init_err_r  <= 1'b0;
      err_code_r  <= 3'd0;
      card_v2_r   <= 1'b0;
      card_hc_r   <= 1'b0;
    end else if (start && !busy_r) begin
      state_r     <= ST_DUMMY;
      cmd_r       <= C_CMD0;
      cnt_r       <= 8'd0;
      retry_r     <= 16'd0;
      xfer_req_r  <= 1'b1;
      xfer_tx_r   <= 8'hFF;
      cs_assert_r <= 1'b0;
      busy_r      <= 1'b1;
      init_done_r <= 1'b0;
      init_err_r  <= 1'b0;
      err_code_r  <= 3'd0;
      card_v2_r   <= 1'b0;
      card_hc_r   <= 1'b0;
    end else if (accept_s) begin
      state_r     <= state_n;
      cmd_r       <= cmd_n;
      cnt_r       <= cnt_n;
      retry_r     <= retry_n;
      tail_r      <= (state_r == ST_RESP_TAIL) ? tail_s : tail_r;
      xfer_req_r  <= 1'b0;
      busy_r      <= (state_n != ST_DONE) && (state_n != ST_ERR);
      init_done_r <= (state_n == ST_DONE);
      init_err_r  <= (state_n == ST_ERR);
      err_code_r  <= code_n;
      card_v2_r   <= v2_n;
      card_hc_r   <= hc_n;
    end else if (busy_r && !xfer_req_r) begin
      // one idle cycle after each completion, then present the next byte
      xfer_req_r  <= 1'b1;
      xfer_tx_r   <= tx_s;
      cs_assert_r <= cs_s;
    end else begin
      xfer_req_r  <= xfer_req_r;
    end
  end

endmodule
